// File: rtl/dep_track_table_if.sv
`default_nettype none
// ============================================================================
// Module      : dep_track_table_if
// Description : Handshake bundle for the dependency tracking table.
//               master modport = requester side (drives alloc/retire/scan
//               requests), slave modport = table side.
//               Signals:
//                 alloc_valid/alloc_ready/alloc_rd/alloc_rs/alloc_idx
//                   - allocation at tail, flat source list (src k at k*RW)
//                 retire_valid/retire_idx
//                   - retire (clear valid) of one entry
//                 scan_start/scan_busy/scan_done/scan_found/scan_idx
//                   - oldest-issuable search request and result
//                 occupancy
//                   - slots held between head and tail
// Revision    : 1.0 - initial release
// ============================================================================
interface dep_track_table_if #(
  parameter int BS     = 32,
  parameter int REGNUM = 16,
  parameter int NSRC   = 2
);
  localparam int RW = $clog2(REGNUM);
  localparam int IW = $clog2(BS);

  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [RW-1:0]        alloc_rd;
  logic [NSRC*RW-1:0]   alloc_rs;
  logic [IW-1:0]        alloc_idx;
  logic                 retire_valid;
  logic [IW-1:0]        retire_idx;
  logic                 scan_start;
  logic                 scan_busy;
  logic                 scan_done;
  logic                 scan_found;
  logic [IW-1:0]        scan_idx;
  logic [IW:0]          occupancy;

  modport master (
    output alloc_valid, alloc_rd, alloc_rs, retire_valid, retire_idx, scan_start,
    input  alloc_ready, alloc_idx, scan_busy, scan_done, scan_found, scan_idx, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_rs, retire_valid, retire_idx, scan_start,
    output alloc_ready, alloc_idx, scan_busy, scan_done, scan_found, scan_idx, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/dep_track_table.sv
`default_nettype none
// ============================================================================
// Module      : dep_track_table
// Description : Circular in-order table of in-flight instructions with
//               register one-hot masks, plus a sequential scanner that finds
//               the oldest entry free of RAW/WAW/WAR hazards against all
//               older, still-pending entries and marks it issued.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - dep_track_table_if.slave (alloc / retire / scan /
//                      occupancy signals)
// Revision    : 1.0 - initial release
// ============================================================================
module dep_track_table #(
  parameter int BS     = 32,
  parameter int REGNUM = 16,
  parameter int NSRC   = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dep_track_table_if.slave  bus
);

  localparam int c_RW = $clog2(REGNUM);
  localparam int c_IW = $clog2(BS);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int c_PW = c_IW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [BS-1:0]      r_valid;
  logic [BS-1:0]      r_issued;
  logic [REGNUM-1:0]  r_rd_mask [BS];
  logic [REGNUM-1:0]  r_rs_mask [BS];
  logic [c_PW-1:0]    r_head;
  logic [c_PW-1:0]    r_tail;

  scan_state_t        r_state;
  scan_state_t        w_state_nxt;
  logic [c_PW-1:0]    r_ptr;
  logic [c_PW-1:0]    r_end;
  logic [REGNUM-1:0]  r_acc_rd;
  logic [REGNUM-1:0]  r_acc_rs;
  logic               r_found;
  logic [c_IW-1:0]    r_idx;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [c_PW-1:0]    w_occ;
  logic               w_alloc_ready;
  logic               w_alloc_fire;
  logic               w_retire_fire;
  logic               w_reclaim;
  logic [c_IW-1:0]    w_head_idx;
  logic [c_IW-1:0]    w_tail_idx;
  logic [c_IW-1:0]    w_ptr_idx;
  logic [REGNUM-1:0]  w_alloc_rd_mask;
  logic [REGNUM-1:0]  w_alloc_rs_mask;
  logic               w_ptr_retiring;
  logic               w_issuable;
  logic               w_scan_capture;
  logic               w_scan_end;
  logic               w_scan_hit;
  logic               w_scan_step;
  logic               w_scan_accum;

  // Register 0 is hard-wired and never creates a dependency, so it maps to
  // an empty mask.
  function automatic logic [REGNUM-1:0] f_onehot(input logic [c_RW-1:0] reg_num);
    logic [REGNUM-1:0] mask;
    mask = '0;
    if (reg_num != '0) mask[reg_num] = 1'b1;
    return mask;
  endfunction

  always_comb begin
    w_alloc_rd_mask = f_onehot(bus.alloc_rd);
    w_alloc_rs_mask = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_alloc_rs_mask = w_alloc_rs_mask | f_onehot(bus.alloc_rs[k*c_RW +: c_RW]);
    end
  end

  assign w_head_idx    = r_head[c_IW-1:0];
  assign w_tail_idx    = r_tail[c_IW-1:0];
  assign w_ptr_idx     = r_ptr[c_IW-1:0];
  assign w_occ         = r_tail - r_head;
  assign w_alloc_ready = (w_occ < c_PW'(BS));
  assign w_alloc_fire  = bus.alloc_valid & w_alloc_ready;
  assign w_retire_fire = bus.retire_valid & r_valid[bus.retire_idx];
  // Reclaim looks at the registered valid bit, so a head retire frees its
  // slot on the following edge.
  assign w_reclaim     = (w_occ != '0) & ~r_valid[w_head_idx];

  // An entry retired on the very cycle it is examined must not be picked.
  assign w_ptr_retiring = bus.retire_valid & (bus.retire_idx == w_ptr_idx);

  assign w_issuable = r_valid[w_ptr_idx]
                    & ~r_issued[w_ptr_idx]
                    & ~w_ptr_retiring
                    & ((r_rs_mask[w_ptr_idx] & r_acc_rd) == '0)   // RAW
                    & ((r_rd_mask[w_ptr_idx] & r_acc_rd) == '0)   // WAW
                    & ((r_rd_mask[w_ptr_idx] & r_acc_rs) == '0);  // WAR

  // --------------------------------------------------------------------------
  // Scan FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_scan_capture = 1'b0;
    w_scan_end     = 1'b0;
    w_scan_hit     = 1'b0;
    w_scan_step    = 1'b0;
    w_scan_accum   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.scan_start) begin
          w_state_nxt    = S_SCAN;
          w_scan_capture = 1'b1;
        end
      end
      S_SCAN: begin
        if (r_ptr == r_end) begin
          w_state_nxt = S_DONE;
          w_scan_end  = 1'b1;
        end else if (w_issuable) begin
          w_state_nxt = S_DONE;
          w_scan_hit  = 1'b1;
        end else begin
          w_scan_step  = 1'b1;
          // Skipped entries still pending constrain everything younger.
          w_scan_accum = r_valid[w_ptr_idx];
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Scan datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_end    <= '0;
      r_acc_rd <= '0;
      r_acc_rs <= '0;
      r_found  <= 1'b0;
      r_idx    <= '0;
    end else begin
      if (w_scan_capture) begin
        // The end point is frozen here: later allocations are not scanned.
        r_ptr    <= r_head;
        r_end    <= r_tail;
        r_acc_rd <= '0;
        r_acc_rs <= '0;
      end
      if (w_scan_accum) begin
        r_acc_rd <= r_acc_rd | r_rd_mask[w_ptr_idx];
        r_acc_rs <= r_acc_rs | r_rs_mask[w_ptr_idx];
      end
      if (w_scan_step) begin
        r_ptr <= r_ptr + c_PW'(1);
      end
      if (w_scan_end) begin
        r_found <= 1'b0;
      end
      if (w_scan_hit) begin
        r_found <= 1'b1;
        r_idx   <= w_ptr_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Table state: alloc, retire, issue marking and head reclaim
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_issued <= '0;
      for (int i = 0; i < BS; i++) begin
        r_rd_mask[i] <= '0;
        r_rs_mask[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_retire_fire) begin
        r_valid[bus.retire_idx] <= 1'b0;
      end
      if (w_scan_hit) begin
        r_issued[w_ptr_idx] <= 1'b1;
      end
      // The tail slot is never a live entry while not full, so it cannot
      // collide with the retire or issue writes above.
      if (w_alloc_fire) begin
        r_valid[w_tail_idx]   <= 1'b1;
        r_issued[w_tail_idx]  <= 1'b0;
        r_rd_mask[w_tail_idx] <= w_alloc_rd_mask;
        r_rs_mask[w_tail_idx] <= w_alloc_rs_mask;
        r_tail                <= r_tail + c_PW'(1);
      end
      if (w_reclaim) begin
        r_head <= r_head + c_PW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.alloc_ready = w_alloc_ready;
  assign bus.alloc_idx   = w_tail_idx;
  assign bus.occupancy   = w_occ;
  assign bus.scan_busy   = (r_state != S_IDLE);
  assign bus.scan_done   = (r_state == S_DONE);
  assign bus.scan_found  = r_found;
  assign bus.scan_idx    = r_idx;

endmodule
`default_nettype wire
